// File: rtl/mod7_reconstruct.sv
// mod7_reconstruct
//
// Rebuilds an operand from its divide-by-7 decomposition: N = 7*Q + R.
// The multiply is done bit-serially (one quotient bit per cycle, MSB
// first) with a shift-and-add accumulator, followed by a single add of
// the remainder. A remainder of 7 is not a legal mod-7 value, so it is
// reported through err and the multiply is skipped.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset, aborts any conversion
//   start  - conversion request, only honoured while busy is low
//   q_in   - quotient (QW bits), captured on an accepted start
//   r_in   - remainder (3 bits), captured on an accepted start
//   busy   - high while a conversion is in flight
//   done   - one-cycle pulse when n_out/err are valid
//   n_out  - result 7*Q+R (QW+3 bits), held until the next accepted start
//   err    - set with done when the captured remainder was 7

module mod7_reconstruct #(
    parameter int QW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [QW-1:0] q_in,
    input  logic [2:0]    r_in,
    output logic          busy,
    output logic          done,
    output logic [QW+2:0] n_out,
    output logic          err
);

    localparam int NW = QW + 3;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] ADD  = 2'd2;

    localparam logic [NW-1:0] SEVEN   = NW'(7);
    localparam logic [CW-1:0] CNT_TOP = CW'(QW - 1);

    logic [1:0]    state_q, state_d;
    logic [QW-1:0] qsr_q,   qsr_d;
    logic [2:0]    r_q,     r_d;
    logic [NW-1:0] acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [NW-1:0] n_q,     n_d;
    logic          err_q,   err_d;
    logic          done_q,  done_d;

    // Next-state logic. The accumulator doubles every MUL cycle and adds 7
    // whenever the current quotient MSB is set, so after QW cycles it
    // holds 7*Q. The result fits NW bits, so no overflow handling is
    // needed anywhere in the datapath.
    always_comb begin
        state_d = state_q;
        qsr_d   = qsr_q;
        r_d     = r_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    qsr_d   = q_in;
                    r_d     = r_in;
                    acc_d   = '0;
                    cnt_d   = CNT_TOP;
                    n_d     = '0;
                    err_d   = 1'b0;
                    // An illegal remainder makes the product irrelevant,
                    // so jump straight to the final step.
                    state_d = (r_in == 3'd7) ? ADD : MUL;
                end
            end

            MUL: begin
                acc_d = (acc_q << 1) + (qsr_q[QW-1] ? SEVEN : '0);
                qsr_d = qsr_q << 1;
                if (cnt_q == '0) begin
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ADD: begin
                if (r_q == 3'd7) begin
                    n_d   = '0;
                    err_d = 1'b1;
                end else begin
                    n_d   = acc_q + {{(NW-3){1'b0}}, r_q};
                    err_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over everything, including a start in
    // the same cycle, and drops an in-flight conversion without a done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            qsr_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qsr_q   <= qsr_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // done is only raised on the edge that returns to IDLE, so busy and
    // done can never be high together.
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign n_out = n_q;
    assign err   = err_q;

endmodule

// File: doc/mod7_reconstruct.md
Name: mod7_reconstruct

Overview:
- Inverse companion to the combinational mod-7 remainder block.
- Given a quotient Q and a remainder R, computes N = 7*Q + R with a multi-cycle, bit-serial shift-and-add datapath.
- Start/busy/done handshake; flags an invalid remainder (R = 7).
- Used to rebuild an operand from its divide-by-7 decomposition and to cross-check the remainder block in system tests.

Parameters:
- QW, 4, quotient width in bits (QW >= 1). Output width NW = QW+3.
- Max result 7*(2^QW-1)+6 = 7*2^QW-1, which always fits NW bits, so no overflow is possible.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when busy=0.
- q_in  input  QW  quotient; captured on an accepted start.
- r_in  input  3  remainder; captured on an accepted start; legal range 0..6.
- busy  output  1  high while a conversion is in flight.
- done  output  1  single-cycle pulse when n_out/err become valid.
- n_out  output  NW  result 7*Q+R; held until the next accepted start.
- err  output  1  high with done if captured R was 7; held with n_out.

Behaviour:
- Reset:
  - Sampled at a rising edge with rst=1; overrides start and all in-flight work.
  - State=IDLE. busy=0, done=0, n_out=0, err=0.
  - Internal accumulator, shift register and counter cleared.
  - Reset mid-conversion aborts it; no done pulse is produced for the aborted request.
- States: IDLE, MUL, ADD.
- IDLE:
  - At an edge with start=1:
    - Capture q_in into a shift register and r_in into a remainder register.
    - acc=0, cnt=QW-1; n_out cleared to 0, err cleared to 0.
    - busy=1; go to MUL.
  - start=0: stay in IDLE; outputs hold.
- Invalid remainder: if the captured r_in==7, go directly to ADD instead of MUL (skip multiply).
- MUL, each edge:
  - acc = (acc<<1) + (qsr[QW-1] ? 7 : 0), computed in NW bits; qsr shifts left by 1.
  - If cnt==0, go to ADD; else cnt--.
  - Exactly QW MUL cycles.
- ADD, one edge:
  - Valid R: n_out=acc+R, err=0.
  - R==7: n_out=0, err=1.
  - done=1, busy=0; go to IDLE.
- done is high for exactly the one cycle following the ADD edge, then returns to 0.
- Latency, counting edges from the accepted start edge:
  - Valid R: done is visible after edge QW+1 (QW=4: 5 edges).
  - R==7: done is visible after edge 1.
- start while busy=1 is ignored: no capture, no effect on the current result.
- start in the cycle done=1 (state already IDLE) is accepted. Back-to-back conversions are legal; n_out/err are cleared at that accepting edge.
- q_in and r_in are don't-care except at an accepted start edge.
- busy and done are never high in the same cycle.

Test Plan:
- Reset, then Q=0, R=2 -> n_out=2, err=0, done pulse after 5 edges (QW=4), busy high for edges 1..4 only.
- Q=1,R=4 -> 11; Q=2,R=1 -> 15; Q=15,R=6 -> 111. Each has a single-cycle done; n_out holds until the next start.
- Sweep all Q=0..15 x R=0..6, feeding each result to the mod-7 remainder block -> recovered remainder equals R and n_out/7 equals Q, every case.
- R=7, Q=5 -> done after 1 edge, err=1, n_out=0. A following valid start (Q=3, R=0) clears err and yields 21.
- Pulse start with Q=9, R=3 on edges 2 and 3 of a running Q=1, R=4 conversion -> result 11 unaffected, no extra done. Start held high through done -> second conversion accepted in the done cycle.
- Assert rst at MUL edge 2 of Q=15, R=6 -> next cycle busy=0, done=0, n_out=0, err=0, no done pulse. A new start with Q=4, R=5 yields 33.
